// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and load/store.
// One transaction outstanding at a time; data has priority, bounded by a fetch anti-starvation streak.
module mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_unsigned_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_size_o,
    output logic        mem_unsigned_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        spurious_rsp_o
);
    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_fetch_q, owner_fetch_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                spurious_q, spurious_d;

    logic fetch_wins;
    logic sel_fetch;
    logic issue;
    logic accept;

    // Winner is chosen live in IDLE and frozen in owner_fetch_q afterwards.
    assign fetch_wins = if_req_i && (!d_req_i || (streak_q == STREAK_MAX));
    assign sel_fetch  = (state_q == IDLE) ? fetch_wins : owner_fetch_q;
    assign issue      = !reset && (((state_q == IDLE) && (if_req_i || d_req_i)) || (state_q == REQ));
    assign accept     = issue && mem_gnt_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_fetch_q <= 1'b1;
            streak_q      <= '0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_fetch_q <= owner_fetch_d;
            streak_q      <= streak_d;
            spurious_q    <= spurious_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_fetch_d = owner_fetch_q;
        streak_d      = streak_q;
        spurious_d    = spurious_q || (mem_rvalid_i && (state_q != WAIT_RESP));
        case (state_q)
            IDLE: begin
                if (issue) begin
                    owner_fetch_d = fetch_wins;
                    state_d       = mem_gnt_i ? WAIT_RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Streak counts data grants that made a waiting fetch wait.
        if (accept) begin
            if (sel_fetch || !if_req_i) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    always_comb begin
        mem_req_o      = issue;
        mem_addr_o     = '0;
        mem_we_o       = 1'b0;
        mem_size_o     = '0;
        mem_unsigned_o = 1'b0;
        mem_wdata_o    = '0;
        if_gnt_o       = accept && sel_fetch;
        d_gnt_o        = accept && !sel_fetch;
        if_rvalid_o    = 1'b0;
        d_rvalid_o     = 1'b0;
        if (issue) begin
            if (sel_fetch) begin
                mem_addr_o = if_addr_i;
                mem_size_o = SIZE_WORD;
            end else begin
                mem_addr_o     = d_addr_i;
                mem_we_o       = d_we_i;
                mem_size_o     = d_size_i;
                mem_unsigned_o = d_unsigned_i;
                mem_wdata_o    = d_wdata_i;
            end
        end
        if ((state_q == WAIT_RESP) && mem_rvalid_i) begin
            if_rvalid_o = owner_fetch_q;
            d_rvalid_o  = !owner_fetch_q;
        end
    end

    assign if_rdata_o     = mem_rdata_i;
    assign d_rdata_o      = mem_rdata_i;
    assign busy_o         = (state_q != IDLE);
    assign spurious_rsp_o = spurious_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle transaction-level model plus literal expectations.
module tb_mem_arbiter;
    localparam int unsigned MAX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic        d_we_i;
    logic [1:0]  d_size_i;
    logic        d_unsigned_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [1:0]  mem_size_o;
    logic        mem_unsigned_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        busy_o, spurious_rsp_o;

    logic auto_rsp  = 1'b1;
    logic force_rsp = 1'b0;
    logic auto_rv   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0 = nothing pending, 1 = request locked, 2 = response outstanding.
    int  ph       = 0;
    bit  m_fetch  = 1'b1;
    int  m_streak = 0;
    bit  m_spur   = 1'b0;
    byte gq[$];

    always #5 clock = ~clock;

    mem_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
        .clock(clock), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
        .d_unsigned_i(d_unsigned_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_size_o(mem_size_o), .mem_unsigned_o(mem_unsigned_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o)
    );

    function automatic logic [31:0] rsp_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    // RAM responds exactly one cycle after each accepted request.
    always @(posedge clock) begin
        auto_rv     <= mem_req_o && mem_gnt_i && auto_rsp;
        mem_rdata_i <= rsp_word(mem_addr_o);
    end
    assign mem_rvalid_i = auto_rv || force_rsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit fetch_pick();
        return if_req_i && (!d_req_i || (m_streak == int'(MAX)));
    endfunction

    task automatic model_reset();
        ph = 0; m_fetch = 1'b1; m_streak = 0; m_spur = 1'b0;
    endtask

    task automatic model_grant();
        if (m_fetch || !if_req_i) m_streak = 0;
        else if (m_streak < int'(MAX)) m_streak = m_streak + 1;
    endtask

    // Advance model on the clock edge, using inputs that are stable there.
    task automatic model_update();
        if (reset) begin
            model_reset();
        end else begin
            if (mem_rvalid_i && ph != 2) m_spur = 1'b1;
            case (ph)
                0: if (if_req_i || d_req_i) begin
                    m_fetch = fetch_pick();
                    if (mem_gnt_i) begin model_grant(); ph = 2; end
                    else ph = 1;
                end
                1: if (mem_gnt_i) begin model_grant(); ph = 2; end
                default: if (mem_rvalid_i) ph = 0;
            endcase
        end
    endtask

    task automatic model_check();
        bit e_req, e_who, e_rv;
        if (reset) begin
            model_reset();
            chk("rst_mem_req", 32'(mem_req_o), 32'd0);
            chk("rst_mem_addr", mem_addr_o, 32'd0);
            chk("rst_mem_ctl", 32'({mem_we_o, mem_size_o, mem_unsigned_o}), 32'd0);
            chk("rst_mem_wdata", mem_wdata_o, 32'd0);
            chk("rst_gnt", 32'({if_gnt_o, d_gnt_o}), 32'd0);
            chk("rst_rvalid", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_spur", 32'(spurious_rsp_o), 32'd0);
            return;
        end
        e_req = (ph == 0) ? (if_req_i || d_req_i) : (ph == 1);
        e_who = (ph == 0) ? fetch_pick() : m_fetch;
        e_rv  = (ph == 2) && mem_rvalid_i;
        chk("m_mem_req", 32'(mem_req_o), 32'(e_req));
        if (e_req) begin
            chk("m_mem_addr", mem_addr_o, e_who ? if_addr_i : d_addr_i);
            chk("m_mem_ctl", 32'({mem_we_o, mem_size_o, mem_unsigned_o}),
                e_who ? 32'b0100 : 32'({d_we_i, d_size_i, d_unsigned_i}));
            chk("m_mem_wdata", mem_wdata_o, e_who ? 32'd0 : d_wdata_i);
        end
        chk("m_if_gnt", 32'(if_gnt_o), 32'(e_req && mem_gnt_i && e_who));
        chk("m_d_gnt", 32'(d_gnt_o), 32'(e_req && mem_gnt_i && !e_who));
        chk("m_if_rvalid", 32'(if_rvalid_o), 32'(e_rv && m_fetch));
        chk("m_d_rvalid", 32'(d_rvalid_o), 32'(e_rv && !m_fetch));
        if (e_rv) begin
            chk("m_if_rdata", if_rdata_o, mem_rdata_i);
            chk("m_d_rdata", d_rdata_o, mem_rdata_i);
        end
        chk("m_busy", 32'(busy_o), 32'(ph != 0));
        chk("m_spur", 32'(spurious_rsp_o), 32'(m_spur));
    endtask

    task automatic sample();
        @(negedge clock);
        model_check();
        if (if_gnt_o) gq.push_back("F");
        if (d_gnt_o)  gq.push_back("D");
    endtask

    task automatic next();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_addr_i = '0; d_we_i = 1'b0; d_size_i = '0;
        d_unsigned_i = 1'b0; d_wdata_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        sample(); next(); sample(); next();
        reset = 1'b0;
        gq.delete();
    endtask

    task automatic wait_gnt(input bit fetch, input int bound, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            sample();
            if (fetch ? if_gnt_o : d_gnt_o) begin ok = 1'b1; break; end
            next();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: grant not seen within %0d cycles", name, bound);
        end
    endtask

    initial begin
        string exp3;
        // Requests held during reset must not leak onto the RAM port.
        reset = 1'b1; mem_gnt_i = 1'b1;
        clear_inputs();
        if_req_i = 1'b1; if_addr_i = 32'h1234; d_req_i = 1'b1; d_addr_i = 32'h88;
        sample();
        chk("rst_lit_req", 32'(mem_req_o), 32'd0);
        next(); sample(); next();

        // Single fetch, immediate grant, response next cycle.
        do_reset();
        if_req_i = 1'b1; if_addr_i = 32'h0;
        sample();
        chk("t1_if_gnt", 32'(if_gnt_o), 32'd1);
        chk("t1_busy_idle", 32'(busy_o), 32'd0);
        next(); if_req_i = 1'b0;
        sample();
        chk("t1_if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("t1_if_rdata", if_rdata_o, 32'h0050_0093);
        chk("t1_d_rvalid", 32'(d_rvalid_o), 32'd0);
        chk("t1_busy_wait", 32'(busy_o), 32'd1);
        next(); sample();
        chk("t1_busy_done", 32'(busy_o), 32'd0);
        chk("t1_if_rvalid_off", 32'(if_rvalid_o), 32'd0);
        next();

        // Both requesting at streak 0: data wins, fetch follows.
        do_reset();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        d_req_i = 1'b1; d_addr_i = 32'h40; d_size_i = 2'b00; d_unsigned_i = 1'b1;
        sample();
        chk("t2_d_gnt", 32'(d_gnt_o), 32'd1);
        chk("t2_if_gnt", 32'(if_gnt_o), 32'd0);
        chk("t2_addr", mem_addr_o, 32'h40);
        chk("t2_size", 32'(mem_size_o), 32'd0);
        chk("t2_unsigned", 32'(mem_unsigned_o), 32'd1);
        next(); d_req_i = 1'b0;
        wait_gnt(1'b1, 6, "t2_fetch_gnt");
        next(); if_req_i = 1'b0;
        sample(); next(); sample(); next();
        chk("t2_seq_len", 32'(gq.size()), 32'd2);
        if (gq.size() == 2) begin
            chk("t2_seq0", 32'(gq[0]), 32'("D"));
            chk("t2_seq1", 32'(gq[1]), 32'("F"));
        end

        // Continuous contention: anti-starvation pattern.
        do_reset();
        if_req_i = 1'b1; if_addr_i = 32'h300;
        d_req_i = 1'b1; d_addr_i = 32'h48; d_size_i = 2'b10;
        for (int i = 0; i < 40 && gq.size() < 10; i++) begin sample(); next(); end
        clear_inputs();
        sample(); next(); sample(); next();
        exp3 = "DDDDFDDDDF";
        chk("t3_seq_len", 32'(gq.size()), 32'd10);
        for (int i = 0; i < 10 && i < gq.size(); i++) chk("t3_seq", 32'(gq[i]), 32'(exp3[i]));

        // Locked fetch survives a later data request while RAM stalls.
        do_reset();
        mem_gnt_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h200;
        sample();
        chk("t4_req", 32'(mem_req_o), 32'd1);
        chk("t4_addr0", mem_addr_o, 32'h200);
        next();
        d_req_i = 1'b1; d_addr_i = 32'h44; d_size_i = 2'b01;
        sample();
        chk("t4_addr1", mem_addr_o, 32'h200);
        chk("t4_d_gnt1", 32'(d_gnt_o), 32'd0);
        next(); sample();
        chk("t4_addr2", mem_addr_o, 32'h200);
        next(); mem_gnt_i = 1'b1;
        sample();
        chk("t4_if_gnt", 32'(if_gnt_o), 32'd1);
        chk("t4_d_gnt3", 32'(d_gnt_o), 32'd0);
        next(); if_req_i = 1'b0;
        sample();
        chk("t4_if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("t4_d_gnt_rv", 32'(d_gnt_o), 32'd0);
        next(); sample();
        chk("t4_d_gnt", 32'(d_gnt_o), 32'd1);
        chk("t4_d_addr", mem_addr_o, 32'h44);
        chk("t4_d_size", 32'(mem_size_o), 32'd1);
        next(); d_req_i = 1'b0;
        sample();
        chk("t4_d_rvalid", 32'(d_rvalid_o), 32'd1);
        next(); sample(); next();

        // Store with one stall cycle.
        do_reset();
        mem_gnt_i = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b1; d_wdata_i = 32'hDEAD_BEEF; d_size_i = 2'b10; d_addr_i = 32'h80;
        sample();
        chk("t5_we", 32'(mem_we_o), 32'd1);
        chk("t5_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("t5_no_gnt", 32'(d_gnt_o), 32'd0);
        next(); mem_gnt_i = 1'b1;
        sample();
        chk("t5_d_gnt", 32'(d_gnt_o), 32'd1);
        chk("t5_we_gnt", 32'(mem_we_o), 32'd1);
        chk("t5_wdata_gnt", mem_wdata_o, 32'hDEAD_BEEF);
        next(); clear_inputs();
        sample();
        chk("t5_d_rvalid", 32'(d_rvalid_o), 32'd1);
        chk("t5_if_rvalid", 32'(if_rvalid_o), 32'd0);
        next(); sample();
        chk("t5_d_rvalid_off", 32'(d_rvalid_o), 32'd0);
        next();

        // Reset while a response is outstanding; late response is spurious.
        do_reset();
        auto_rsp = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        sample();
        chk("t6_if_gnt", 32'(if_gnt_o), 32'd1);
        next(); if_req_i = 1'b0;
        sample();
        chk("t6_busy_wait", 32'(busy_o), 32'd1);
        next(); reset = 1'b1;
        sample();
        chk("t6_busy_rst", 32'(busy_o), 32'd0);
        next(); reset = 1'b0;
        sample();
        chk("t6_busy_idle", 32'(busy_o), 32'd0);
        next(); force_rsp = 1'b1;
        sample();
        chk("t6_rvalids", 32'({if_rvalid_o, d_rvalid_o}), 32'd0);
        next(); force_rsp = 1'b0;
        sample();
        chk("t6_spur_set", 32'(spurious_rsp_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            next(); sample();
            chk("t6_spur_hold", 32'(spurious_rsp_o), 32'd1);
        end
        next(); reset = 1'b1;
        sample();
        chk("t6_spur_clr", 32'(spurious_rsp_o), 32'd0);
        next(); reset = 1'b0; auto_rsp = 1'b1;
        sample();
        chk("t6_spur_after", 32'(spurious_rsp_o), 32'd0);
        next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
